// File: rtl/mem_access_unit.sv
// Load/store sequencer that sits in front of the data memory. It holds the Rm/Wm strobes for a
// fixed window and hands load results to writeback. Defining MAU_ADDR_CHECK_EN enables dropping of out-of-range requests.
module mem_access_unit #(
  parameter int READ_LAT  = 2,
  parameter int WRITE_CYC = 1
`ifdef MAU_ADDR_CHECK_EN
  , parameter int MEM_DEPTH = 256
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [2:0] req_rd,
  output logic       Rm,
  output logic       Wm,
  output logic [7:0] address,
  output logic [7:0] RegVal,
  input  logic [7:0] Data_out,
  output logic       wb_valid,
  input  logic       wb_ready,
  output logic [2:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       fault,
  output logic [1:0] dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high. The source
  // must hold its payload until then. req_ready is high only in IDLE. wb_data/wb_rd are stable while wb_valid is high.
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_WB} state_e;

  localparam logic [3:0] READ_LAST  = 4'(READ_LAT - 1);
  localparam logic [3:0] WRITE_LAST = 4'(WRITE_CYC - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [2:0] rd_q;
  logic       rm_q, wm_q, wb_valid_q, req_ready_q;
  logic [7:0] address_q, regval_q, wb_data_q;
  logic [2:0] wb_rd_q;
  logic       addr_ok;

`ifdef MAU_ADDR_CHECK_EN
  logic fault_q;
  assign addr_ok = ({24'd0, req_addr} < MEM_DEPTH);
  assign fault   = fault_q;
`else
  assign addr_ok = 1'b1;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rd_q        <= 3'd0;
      rm_q        <= 1'b0;
      wm_q        <= 1'b0;
      wb_valid_q  <= 1'b0;
      req_ready_q <= 1'b1;
      address_q   <= 8'h00;
      regval_q    <= 8'h00;
      wb_data_q   <= 8'h00;
      wb_rd_q     <= 3'd0;
`ifdef MAU_ADDR_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
`ifdef MAU_ADDR_CHECK_EN
      fault_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            address_q <= req_addr;
            regval_q  <= req_wdata;
            rd_q      <= req_rd;
            cnt_q     <= 4'd0;
            // A dropped request stays in IDLE, so the unit remains ready for the next request.
            if (!addr_ok) begin
`ifdef MAU_ADDR_CHECK_EN
              fault_q <= 1'b1;
`endif
            end else if (req_we) begin
              state_q     <= S_WRITE;
              wm_q        <= 1'b1;
              req_ready_q <= 1'b0;
            end else begin
              state_q     <= S_READ;
              rm_q        <= 1'b1;
              req_ready_q <= 1'b0;
            end
          end
        end
        S_READ: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == READ_LAST) begin
            wb_data_q  <= Data_out;
            wb_rd_q    <= rd_q;
            rm_q       <= 1'b0;
            wb_valid_q <= 1'b1;
            state_q    <= S_WB;
          end
        end
        S_WRITE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == WRITE_LAST) begin
            wm_q        <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rm_q        <= 1'b0;
          wm_q        <= 1'b0;
          wb_valid_q  <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign Rm          = rm_q;
  assign Wm          = wm_q;
  assign address     = address_q;
  assign RegVal      = regval_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. A transaction-level memory model predicts the load data.
// It covers the checked build and the unchecked build of MAU_ADDR_CHECK_EN.
module tb_mem_access_unit;
  localparam int RL = 2;
  localparam int WC = 3;
`ifdef MAU_ADDR_CHECK_EN
  localparam int ADDR_MAX = 7;
`else
  localparam int ADDR_MAX = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic [2:0] req_rd;
  logic       Rm, Wm;
  logic [7:0] address, RegVal, Data_out;
  logic       wb_valid, wb_ready;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       fault;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;

  // Environment memory and transaction-level reference contents.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] stored_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) if (Wm) mem[address] <= RegVal;
  assign Data_out = Rm ? mem[address] : 8'h5A;

  mem_access_unit #(
    .READ_LAT(RL),
    .WRITE_CYC(WC)
`ifdef MAU_ADDR_CHECK_EN
    , .MEM_DEPTH(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .Rm(Rm), .Wm(Wm), .address(address), .RegVal(RegVal), .Data_out(Data_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault(fault), .dbg_state_o(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [2:0] rd, input int stall);
    int n;
    logic [7:0] exp_data;
    exp_data = ref_mem[addr];
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_before_accept: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_rd = rd;
    step();
    req_valid = 1'b0;
    n = 0;
    while ((Rm || Wm) && n < 40) begin
      checks++;
      if ((Rm && Wm) || (Wm !== we) || (address !== addr) || (RegVal !== wdata) || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL strobe_window: Rm=%b Wm=%b addr=%h data=%h rdy=%b want we=%b addr=%h data=%h rdy=0",
                 Rm, Wm, address, RegVal, req_ready, we, addr, wdata);
      end
      n++;
      step();
    end
    checks++;
    if (n != (we ? WC : RL)) begin
      failures++;
      $display("FAIL strobe_len: got %0d cycles want %0d", n, we ? WC : RL);
    end
    if (!we) begin
      for (int s = 0; s <= stall; s++) begin
        if (s > 0) step();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== exp_data || wb_rd !== rd || req_ready !== 1'b0) begin
          failures++;
          $display("FAIL wb_result: valid=%b data=%h rd=%0d rdy=%b want 1 %h %0d 0",
                   wb_valid, wb_data, wb_rd, req_ready, exp_data, rd);
        end
      end
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
    end else begin
      ref_mem[addr] = wdata;
      stored_q.push_back(addr);
    end
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1 || Rm !== 1'b0 || Wm !== 1'b0) begin
      failures++;
      $display("FAIL retire: valid=%b rdy=%b Rm=%b Wm=%b want 0 1 0 0", wb_valid, req_ready, Rm, Wm);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || Rm !== 1'b0 || Wm !== 1'b0 || wb_valid !== 1'b0 || fault !== 1'b0 ||
        address !== 8'h00 || RegVal !== 8'h00 || wb_data !== 8'h00 || wb_rd !== 3'd0) begin
      failures++;
      $display("FAIL reset_values: rdy=%b Rm=%b Wm=%b v=%b f=%b a=%h r=%h d=%h rd=%0d want 1 0 0 0 0 00 00 00 0",
               req_ready, Rm, Wm, wb_valid, fault, address, RegVal, wb_data, wb_rd);
    end
  endtask

  task automatic test_store_load();
    do_req(1'b1, 8'h00, 8'h01, 3'd0, 0);
    do_req(1'b0, 8'h00, 8'h00, 3'd5, 0);
  endtask

  task automatic test_wb_stall();
    do_req(1'b1, 8'h01, 8'hC3, 3'd0, 0);
    do_req(1'b0, 8'h01, 8'h00, 3'd2, 5);
  endtask

  task automatic test_busy();
    int n;
    bit seen_wb;
    logic [7:0] b_addr, b_data;
    b_addr = 8'($urandom_range(0, ADDR_MAX));
    b_data = 8'($urandom);
    wb_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; req_rd = 3'd6; req_wdata = 8'h00;
    step();
    req_we = 1'b1; req_addr = b_addr; req_wdata = b_data; req_rd = 3'd1;
    n = 0; seen_wb = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      checks++;
      if ((Rm && Wm) || address !== 8'h00) begin
        failures++;
        $display("FAIL busy_hold: Rm=%b Wm=%b addr=%h want exclusive strobes addr=00", Rm, Wm, address);
      end
      if (wb_valid) begin
        seen_wb = 1;
        checks++;
        if (wb_data !== ref_mem[8'h00] || wb_rd !== 3'd6) begin
          failures++;
          $display("FAIL busy_wb: data=%h rd=%0d want %h 6", wb_data, wb_rd, ref_mem[8'h00]);
        end
      end
      n++;
      step();
    end
    wb_ready = 1'b0;
    checks++;
    if (!seen_wb || n != RL + 1) begin
      failures++;
      $display("FAIL busy_latency: busy=%0d wb_seen=%0d want %0d 1", n, seen_wb, RL + 1);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (Wm !== 1'b1 || address !== b_addr || RegVal !== b_data) begin
      failures++;
      $display("FAIL busy_accept: Wm=%b addr=%h data=%h want 1 %h %h", Wm, address, RegVal, b_addr, b_data);
    end
    n = 0;
    while (Wm && n < 40) begin n++; step(); end
    checks++;
    if (n != WC) begin
      failures++;
      $display("FAIL busy_store_len: got %0d want %0d", n, WC);
    end
    ref_mem[b_addr] = b_data;
    stored_q.push_back(b_addr);
  endtask

  task automatic test_random();
    logic we;
    logic [7:0] addr;
    for (int i = 0; i < 40; i++) begin
      we = (stored_q.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      addr = we ? 8'($urandom_range(0, ADDR_MAX)) : stored_q[$urandom_range(0, stored_q.size() - 1)];
      do_req(we, addr, 8'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_store();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h02; req_wdata = 8'hA5; req_rd = 3'd0;
    step();
    req_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1 || Wm !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: rdy=%b Wm=%b want 1 0", req_ready, Wm);
    end
    do_req(1'b1, 8'h02, 8'($urandom), 3'd0, 0);
  endtask

`ifdef MAU_ADDR_CHECK_EN
  task automatic test_addr_check();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h11; req_wdata = 8'h77; req_rd = 3'd0;
    step();
    req_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || Wm !== 1'b0 || Rm !== 1'b0 || address !== 8'h11 || RegVal !== 8'h77) begin
      failures++;
      $display("FAIL fault_pulse: f=%b Wm=%b Rm=%b addr=%h data=%h want 1 0 0 11 77", fault, Wm, Rm, address, RegVal);
    end
    step();
    checks++;
    if (fault !== 1'b0 || Wm !== 1'b0 || req_ready !== 1'b1 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL fault_end: f=%b Wm=%b rdy=%b v=%b want 0 0 1 0", fault, Wm, req_ready, wb_valid);
    end
    req_valid = 1'b1; req_addr = 8'h03; req_wdata = 8'h3C;
    step();
    req_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || Wm !== 1'b1 || address !== 8'h03) begin
      failures++;
      $display("FAIL in_range_store: f=%b Wm=%b addr=%h want 0 1 03", fault, Wm, address);
    end
    repeat (WC) step();
    ref_mem[8'h03] = 8'h3C;
    stored_q.push_back(8'h03);
    do_req(1'b0, 8'h03, 8'h00, 3'd4, 0);
  endtask
`else
  task automatic test_macro_off();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h11; req_wdata = 8'h99; req_rd = 3'd0;
    step();
    req_valid = 1'b0;
    checks++;
    if (Wm !== 1'b1 || address !== 8'h11 || fault !== 1'b0) begin
      failures++;
      $display("FAIL no_check_store: Wm=%b addr=%h f=%b want 1 11 0", Wm, address, fault);
    end
    repeat (WC) step();
    ref_mem[8'h11] = 8'h99;
    stored_q.push_back(8'h11);
    do_req(1'b0, 8'h11, 8'h00, 3'd3, 1);
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00;
    req_wdata = 8'h00; req_rd = 3'd0; wb_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    step();
    test_reset();
    test_store_load();
    test_wb_stall();
    test_busy();
    test_random();
    test_reset_mid_store();
`ifdef MAU_ADDR_CHECK_EN
    test_addr_check();
`else
    test_macro_off();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
